// File: rtl/port_pkg.sv
// Shared port definitions: read-FSM state encodings and entry layout helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package port_pkg;

    // Read-side FSM states, shared with the port FSM.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } rd_state_e;

    // Default data path width of the port FSM.
    localparam int PORT_W_WIDTH = 8;

    // A stored entry is {eop, data}; the EOP flag sits just above the data bits.
    function automatic int eop_bit(input int w_width);
        return w_width;
    endfunction

endpackage

// File: rtl/port_buffer_if.sv
// Port-FSM <-> buffer bus: write stream, drain request and drained word stream.
// Latency: n/a (wiring only).
// Backpressure: port_busy flows slave -> master; nothing is stalled here.
interface port_buffer_if #(
    parameter int W_WIDTH = 8
);
    logic               wr_en;
    logic [W_WIDTH-1:0] data_in;
    logic               port_busy;
    logic               pkt_avail;
    logic               rd_en;
    logic [W_WIDTH-1:0] data_out;
    logic               data_valid;
    logic               ovf;

    // Port FSM / stimulus side.
    modport master (
        output wr_en, data_in, rd_en,
        input  port_busy, pkt_avail, data_out, data_valid, ovf
    );

    // Buffer side.
    modport slave (
        input  wr_en, data_in, rd_en,
        output port_busy, pkt_avail, data_out, data_valid, ovf
    );
endinterface

// File: rtl/port_buffer_mem.sv
// Circular store of {eop, data} entries with write/read pointers and fill count.
// Latency: write lands on the clock edge; rd_entry_o is combinational from rd_ptr.
// Backpressure: none; a write while full is discarded and flagged on drop_o.
module port_buffer_mem
    import port_pkg::*;
#(
    parameter int W_WIDTH = 8,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [W_WIDTH-1:0] wr_data_i,
    input  logic             set_eop_i,
    input  logic             pop_i,
    output logic [W_WIDTH:0] rd_entry_o,
    output logic [CW-1:0]    count_o,
    output logic             drop_o
);
    localparam int EOP_IDX = eop_bit(W_WIDTH);

    logic [W_WIDTH:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    last_ptr;
    logic             full;
    logic             push;

    assign full       = (count_q == CW'(DEPTH));
    assign push       = wr_en_i & ~full;
    assign drop_o     = wr_en_i & full;
    assign last_ptr   = wr_ptr_q - AW'(1);
    assign rd_entry_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Next pointers and fill level; simultaneous push and pop leave count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_i) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array: new words land with EOP clear; a packet end later marks the
    // most recently accepted word. Push and set_eop never coincide (set_eop needs wr_en low).
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {1'b0, wr_data_i};
        if (set_eop_i) mem_q[last_ptr][EOP_IDX] <= 1'b1;
    end

    // Pointer and count registers; contents are simply forgotten on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/port_buffer.sv
// Packet buffer between port FSM and drain side; optional drop counter via PORT_BUFFER_DROP_CNT_EN.
// Latency: first drained word registered one cycle after rd_en is sampled, then one word per cycle.
// Backpressure: port_busy advises the writer; words written while full are dropped and ovf sticks.
module port_buffer
    import port_pkg::*;
#(
    parameter int W_WIDTH     = 8,
    parameter int DEPTH       = 16,
    parameter int BUSY_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    port_buffer_if.slave bus
`ifdef PORT_BUFFER_DROP_CNT_EN
    ,
    output logic [7:0]  drop_cnt
`endif
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int EOP_IDX = eop_bit(W_WIDTH);

    logic [W_WIDTH:0]   rd_entry;
    logic [CW-1:0]      count;
    logic [CW-1:0]      free_entries;
    logic               drop;
    logic               wr_en_q;
    logic               pkt_end;
    logic               pop;
    logic               eop_pop;
    logic [CW-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic               ovf_q;
    rd_state_e          state_q;
    logic [W_WIDTH-1:0] data_out_q;
    logic               data_valid_q;

    // A packet ends on the first low cycle of wr_en after a high one.
    assign pkt_end = wr_en_q & ~bus.wr_en;
    // Every DRAIN cycle pops one entry; only complete packets are ever drained.
    assign pop     = (state_q == ST_DRAIN);
    assign eop_pop = pop & rd_entry[EOP_IDX];

    port_buffer_mem #(
        .W_WIDTH (W_WIDTH),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (bus.wr_en),
        .wr_data_i  (bus.data_in),
        .set_eop_i  (pkt_end),
        .pop_i      (pop),
        .rd_entry_o (rd_entry),
        .count_o    (count),
        .drop_o     (drop)
    );

    // Complete-packet count; an end and an EOP pop on the same edge cancel out.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (pkt_end && !eop_pop)      pkt_cnt_d = pkt_cnt_q + CW'(1);
        else if (!pkt_end && eop_pop) pkt_cnt_d = pkt_cnt_q - CW'(1);
    end

    // Packet tracking state: wr_en history, packet count, sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            pkt_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_en_q   <= bus.wr_en;
            pkt_cnt_q <= pkt_cnt_d;
            if (drop) ovf_q <= 1'b1;
        end
    end

    // Read FSM with registered outputs: IDLE waits for a request, DRAIN streams to EOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_valid_q <= 1'b0;
                    if (bus.rd_en && (pkt_cnt_q != '0)) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    data_out_q   <= rd_entry[W_WIDTH-1:0];
                    data_valid_q <= 1'b1;
                    if (rd_entry[EOP_IDX]) state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    data_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign free_entries   = CW'(DEPTH) - count;
    assign bus.port_busy  = (free_entries <= CW'(BUSY_MARGIN));
    assign bus.pkt_avail  = (pkt_cnt_q != '0);
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.ovf        = ovf_q;

`ifdef PORT_BUFFER_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    // Dropped-word counter, saturating so it never wraps back to a small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_port_buffer.sv
// Scoreboard bench for port_buffer: expected words queued at write time, popped by a monitor.
// Latency: checks first data_valid one cycle after rd_en is sampled.
// Backpressure: exercises port_busy threshold, overflow drop and sticky ovf.
module tb_port_buffer;
    import port_pkg::*;

    localparam int W = 8;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    port_buffer_if #(.W_WIDTH(W)) bus();
`ifdef PORT_BUFFER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    port_buffer #(
        .W_WIDTH     (W),
        .DEPTH       (D),
        .BUSY_MARGIN (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PORT_BUFFER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int         tests      = 0;
    int         fails      = 0;
    int         valid_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %0h expected none", bus.data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("data_out", 32'(bus.data_out), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] d, input bit keep);
        bus.wr_en   = 1'b1;
        bus.data_in = d;
        if (keep) exp_q.push_back(d);
        tick();
    endtask

    task automatic close_pkt();
        bus.wr_en = 1'b0;
        tick();
    endtask

    // Pulse rd_en, check first-word latency, wait (bounded) for the burst to end.
    task automatic drain(input string name, input int n);
        int start;
        bit done;
        start      = valid_seen;
        bus.rd_en  = 1'b1;
        tick();
        bus.rd_en  = 1'b0;
        @(negedge clk);
        check({name, "_lat0"}, 32'(bus.data_valid), 32'd0);
        @(negedge clk);
        check({name, "_lat1"}, 32'(bus.data_valid), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.data_valid !== 1'b1) done = 1'b1;
        end
        check({name, "_burst_end"}, 32'(done), 32'd1);
        check({name, "_words"}, 32'(valid_seen - start), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int start;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(bus.port_busy), 32'd0);
        check("rst_avail", 32'(bus.pkt_avail), 32'd0);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_dout", 32'(bus.data_out), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        tick();

        // Single packet; a partial packet must not be reported
        put(8'hA1, 1'b1);
        put(8'h10, 1'b1);
        put(8'h20, 1'b1);
        check("partial_avail", 32'(bus.pkt_avail), 32'd0);
        close_pkt();
        check("single_avail", 32'(bus.pkt_avail), 32'd1);
        drain("single", 3);
        check("single_avail_after", 32'(bus.pkt_avail), 32'd0);

        // rd_en with nothing stored is ignored
        tick();
        start     = valid_seen;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        repeat (4) tick();
        check("empty_rd_ignored", 32'(valid_seen - start), 32'd0);

        // Back-to-back packets with a single-cycle gap
        put(8'h61, 1'b1);
        put(8'h62, 1'b1);
        bus.wr_en = 1'b0;
        tick();
        put(8'h71, 1'b1);
        put(8'h72, 1'b1);
        put(8'h73, 1'b1);
        close_pkt();
        check("b2b_pkt_cnt", 32'(dut.pkt_cnt_q), 32'd2);
        drain("b2b_first", 2);
        check("b2b_avail_mid", 32'(bus.pkt_avail), 32'd1);
        drain("b2b_second", 3);
        check("b2b_avail_end", 32'(bus.pkt_avail), 32'd0);
        tick();

        // Fill to capacity: busy from count 14, 17th word dropped
        for (int i = 0; i < 16; i++) begin
            put(8'(8'h30 + i), 1'b1);
            check($sformatf("busy_at_%0d", i + 1), 32'(bus.port_busy), 32'((i + 1) >= 14));
        end
        check("ovf_before_drop", 32'(bus.ovf), 32'd0);
        put(8'hEE, 1'b0);
        check("ovf_after_drop", 32'(bus.ovf), 32'd1);
`ifdef PORT_BUFFER_DROP_CNT_EN
        check("drop_cnt_one", 32'(drop_cnt), 32'd1);
`endif
        close_pkt();
        check("busy_full", 32'(bus.port_busy), 32'd1);
        drain("full", 16);
        check("ovf_sticky", 32'(bus.ovf), 32'd1);
        check("busy_empty", 32'(bus.port_busy), 32'd0);
        tick();

        // Ten 3-word packets, each drained before the next, across pointer wrap
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 3; i++) put(8'(8'h80 + p * 3 + i), 1'b1);
            close_pkt();
            drain($sformatf("wrap%0d", p), 3);
            tick();
        end

        // Packet end on the same edge as the EOP pop of the packet being drained
        put(8'hC1, 1'b1);
        put(8'hC2, 1'b1);
        close_pkt();
        bus.rd_en   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.data_in = 8'hD1;
        exp_q.push_back(8'hD1);
        tick();
        bus.rd_en   = 1'b0;
        bus.data_in = 8'hD2;
        exp_q.push_back(8'hD2);
        tick();
        bus.wr_en = 1'b0;
        tick();
        check("sim_pkt_cnt", 32'(dut.pkt_cnt_q), 32'd1);
        check("sim_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("sim_avail", 32'(bus.pkt_avail), 32'd1);
        repeat (2) tick();
        drain("sim_second", 2);
        tick();

        // Reset during the second DRAIN cycle
        put(8'hE1, 1'b1);
        put(8'hE2, 1'b1);
        put(8'hE3, 1'b1);
        put(8'hE4, 1'b1);
        close_pkt();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.data_valid), 32'd0);
        check("mid_rst_avail", 32'(bus.pkt_avail), 32'd0);
        check("mid_rst_count", 32'(dut.u_mem.count_q), 32'd0);
        check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        check("mid_rst_busy", 32'(bus.port_busy), 32'd0);
`ifdef PORT_BUFFER_DROP_CNT_EN
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        tick();

        // Normal operation resumes after reset
        put(8'h5A, 1'b1);
        put(8'hA5, 1'b1);
        close_pkt();
        drain("post_rst", 2);
        repeat (3) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
